// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback request, hazard query and register-file write bundle
//
// Groups every non-clock signal of rf_wb_arbiter.
//   A requester (ALU)     : a_valid, a_rd[4:0], a_data[31:0] -> a_ready
//   B requester (LSU/mdv) : b_valid, b_rd[4:0], b_data[31:0] -> b_ready
//   Long-latency issue    : iss_valid, iss_rd[4:0]
//   Hazard query          : chk_rs1, chk_rs2, chk_rd [4:0] -> hazard
//   Register file write   : rf_we, rf_rd[4:0], rf_wdata[31:0]
// master: the pipeline/register-file side; slave: the arbiter.
interface rf_wb_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  logic        b_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  modport master (
    output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    output iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd,
    input  a_ready, b_ready, hazard, rf_we, rf_rd, rf_wdata
  );

  modport slave (
    input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
    input  iss_valid, iss_rd, chk_rs1, chk_rs2, chk_rd,
    output a_ready, b_ready, hazard, rf_we, rf_rd, rf_wdata
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter with pending-write scoreboard
//
// Shares the single register-file write port between the single-cycle ALU
// path (A) and the multi-cycle LSU/mul-div path (B). B normally wins; A is
// forced through after STARVE_LIMIT consecutive losses. A 32-entry pending
// scoreboard tracks long-latency destinations and raises hazard to issue.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous, active-high reset
//   bus : rf_wb_arbiter_if.slave (requests, grants, hazard query, RF write)
module rf_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave bus
);

  logic [CNT_W-1:0] r_starve_cnt;
  logic [31:0]      r_pending;
  logic             r_rf_we;
  logic [4:0]       r_rf_rd;
  logic [31:0]      r_rf_wdata;

  logic             w_force_a;
  logic             w_grant_a;
  logic             w_grant_b;
  logic [31:0]      w_pend_view;
  logic [31:0]      w_set_mask;
  logic [31:0]      w_clr_mask;

  assign w_force_a = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // At most one grant; nothing is granted while reset is held.
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (!rst) begin
      if (bus.a_valid && (!bus.b_valid || w_force_a)) begin
        w_grant_a = 1'b1;
      end else if (bus.b_valid) begin
        w_grant_b = 1'b1;
      end
    end
  end

  assign bus.a_ready = w_grant_a;
  assign bus.b_ready = w_grant_b;

  // Entry 0 is masked on the read side so x0 can never report a hazard.
  assign w_pend_view = {r_pending[31:1], 1'b0};
  assign bus.hazard  = w_pend_view[bus.chk_rs1] | w_pend_view[bus.chk_rs2] |
                       w_pend_view[bus.chk_rd];

  assign w_set_mask = (bus.iss_valid && (bus.iss_rd != 5'd0)) ? (32'd1 << bus.iss_rd) : 32'd0;
  assign w_clr_mask = w_grant_b ? (32'd1 << bus.b_rd) : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_pending    <= '0;
      r_rf_we      <= 1'b0;
      r_rf_rd      <= 5'd0;
      r_rf_wdata   <= 32'd0;
    end else begin
      // Starvation count: reset whenever A wins or stops asking.
      if (w_grant_a || !bus.a_valid) begin
        r_starve_cnt <= '0;
      end else if (!w_force_a) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      // Clear applied before set so an issue to the same register wins.
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;

      if (w_grant_a) begin
        r_rf_we    <= (bus.a_rd != 5'd0);
        r_rf_rd    <= bus.a_rd;
        r_rf_wdata <= bus.a_data;
      end else if (w_grant_b) begin
        r_rf_we    <= (bus.b_rd != 5'd0);
        r_rf_rd    <= bus.b_rd;
        r_rf_wdata <= bus.b_data;
      end else begin
        r_rf_we    <= 1'b0;
      end
    end
  end

  assign bus.rf_we    = r_rf_we;
  assign bus.rf_rd    = r_rf_rd;
  assign bus.rf_wdata = r_rf_wdata;

endmodule
